// File: rtl/div_ctrl.sv
// Iterative 32-bit divider for the EX stage: one restoring step per cycle, signed/unsigned
// quotient or remainder, with flush and divide-by-zero handling.
module div_ctrl #(
   parameter int unsigned DIV_ZERO_FAST = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q;
   logic [1:0]  op_q;
   logic [63:0] part_q;
   logic [31:0] divisor_q;
   logic [31:0] src1_q;
   logic        q_neg_q, r_neg_q, zero_q;

   logic        accept, step, signed_op, src2_zero;
   logic [31:0] abs1, abs2;
   logic [63:0] shifted, part_step;
   logic [33:0] diff;
   logic [31:0] quo_fix, rem_fix;

   assign in_ready  = (state_q == StIdle) & ~flush;
   assign out_valid = (state_q == StDone) & ~flush;
   assign busy      = (state_q != StIdle);
   assign accept    = in_valid & in_ready;
   assign step      = (state_q == StCalc) & ~flush;

   assign signed_op = ~op[1];
   assign src2_zero = (src2 == 32'd0);
   assign abs1      = (signed_op & src1[31]) ? -src1 : src1;
   assign abs2      = (signed_op & src2[31]) ? -src2 : src2;

   // part_q[63] is kept in the trial subtract: after the shift the remainder may need 33 bits
   always_comb begin
      shifted   = {part_q[62:0], 1'b0};
      diff      = {1'b0, part_q[63], shifted[63:32]} - {2'b00, divisor_q};
      part_step = shifted;
      if (!diff[33]) begin
         part_step = {diff[31:0], shifted[31:1], 1'b1};
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  state_d = ((DIV_ZERO_FAST != 0) && src2_zero) ? StDone : StCalc;
               end
            end
            StCalc: begin
               if (cnt_q == 6'd31) state_d = StDone;
            end
            StDone: begin
               if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= 6'd0;
         op_q      <= 2'd0;
         part_q    <= 64'd0;
         divisor_q <= 32'd0;
         src1_q    <= 32'd0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         zero_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q     <= 6'd0;
            op_q      <= op;
            part_q    <= {32'd0, abs1};
            divisor_q <= abs2;
            src1_q    <= src1;
            q_neg_q   <= signed_op & (src1[31] ^ src2[31]);
            r_neg_q   <= signed_op & src1[31];
            zero_q    <= src2_zero;
         end else if (step) begin
            cnt_q  <= cnt_q + 6'd1;
            part_q <= part_step;
         end
      end
   end

   // A zero divisor overrides the iterated value: all-ones quotient, raw dividend remainder
   always_comb begin
      quo_fix = q_neg_q ? -part_q[31:0] : part_q[31:0];
      rem_fix = r_neg_q ? -part_q[63:32] : part_q[63:32];
      if (zero_q) begin
         quo_fix = 32'hFFFF_FFFF;
         rem_fix = src1_q;
      end
      result = op_q[0] ? rem_fix : quo_fix;
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: a default instance and a DIV_ZERO_FAST=0 instance share stimulus.
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, flush, out_ready;
   logic [1:0]  op;
   logic [31:0] src1, src2;
   logic        in_ready_f, out_valid_f, busy_f;
   logic        in_ready_s, out_valid_s, busy_s;
   logic [31:0] result_f, result_s;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   div_ctrl #(.DIV_ZERO_FAST(1)) dut_f (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_f), .op(op),
      .src1(src1), .src2(src2), .flush(flush), .out_valid(out_valid_f),
      .out_ready(out_ready), .result(result_f), .busy(busy_f)
   );

   div_ctrl #(.DIV_ZERO_FAST(0)) dut_s (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s), .op(op),
      .src1(src1), .src2(src2), .flush(flush), .out_valid(out_valid_s),
      .out_ready(out_ready), .result(result_s), .busy(busy_s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one request, measure edges to out_valid on both instances, hold, then drain.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat_f_exp,
                         input int hold);
      int lat, lat_f;
      check({tag, " in_ready"}, {31'd0, in_ready_f}, 32'd1);
      in_valid = 1'b1;
      op = o;
      src1 = a;
      src2 = b;
      tick();
      in_valid = 1'b0;
      op = ~o;
      src1 = $urandom;
      src2 = $urandom;
      lat = 0;
      lat_f = -1;
      while (!out_valid_s && lat < 40) begin
         if (out_valid_f && lat_f < 0) lat_f = lat;
         tick();
         lat++;
      end
      if (out_valid_f && lat_f < 0) lat_f = lat;
      check({tag, " lat_fast"}, lat_f, lat_f_exp);
      check({tag, " lat_slow"}, lat, 32'd32);
      check({tag, " res_fast"}, result_f, exp);
      check({tag, " res_slow"}, result_s, exp);
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, " hold_valid"}, {31'd0, out_valid_f}, 32'd1);
         check({tag, " hold_res"}, result_f, exp);
         check({tag, " hold_in_ready"}, {31'd0, in_ready_f}, 32'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, " idle_busy"}, {31'd0, busy_f}, 32'd0);
      check({tag, " idle_valid"}, {31'd0, out_valid_f}, 32'd0);
   endtask

   task automatic no_valid_window(input string tag);
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (out_valid_f || out_valid_s) seen++;
      end
      check({tag, " no_out_valid"}, seen, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      op = 2'b00;
      src1 = 32'd0;
      src2 = 32'd0;
      #1;
      check("rst busy", {31'd0, busy_f}, 32'd0);
      check("rst out_valid", {31'd0, out_valid_f}, 32'd0);
      check("rst result", result_f, 32'd0);
      #12;
      reset = 1'b0;
      tick();
      check("post_rst in_ready", {31'd0, in_ready_f}, 32'd1);

      run_op("div_w 7/-2",      2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32, 5);
      run_op("mod_w 7/-2",      2'b01, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32, 0);
      run_op("mod_w -7/2",      2'b01, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32, 0);
      run_op("div_wu max/2",    2'b10, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 32, 0);
      run_op("mod_wu max/2",    2'b11, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32, 0);
      run_op("div_w ovf",       2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32, 0);
      run_op("mod_w ovf",       2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32, 0);
      run_op("div_wu big",      2'b10, 32'hF000_0000, 32'hC000_0000, 32'h0000_0001, 32, 0);
      run_op("mod_wu big",      2'b11, 32'hF000_0000, 32'hC000_0000, 32'h3000_0000, 32, 0);
      run_op("div_w zero",      2'b00, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 0, 1);
      run_op("mod_wu zero",     2'b11, 32'h1234_5678, 32'd0,         32'h1234_5678, 0, 0);
      run_op("mod_w neg zero",  2'b01, 32'h8765_4321, 32'd0,         32'h8765_4321, 0, 0);

      // Flush at iteration 10 with a competing request in the same cycle
      in_valid = 1'b1;
      op = 2'b00;
      src1 = 32'd100;
      src2 = 32'd3;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      flush = 1'b1;
      in_valid = 1'b1;
      src1 = 32'd50;
      src2 = 32'd5;
      #1;
      check("flush in_ready", {31'd0, in_ready_f}, 32'd0);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush busy", {31'd0, busy_f}, 32'd0);
      check("flush busy_slow", {31'd0, busy_s}, 32'd0);
      no_valid_window("flush");
      check("flush in_ready_after", {31'd0, in_ready_f}, 32'd1);

      // Flush while the result is waiting in DONE
      in_valid = 1'b1;
      op = 2'b10;
      src1 = 32'd9;
      src2 = 32'd3;
      tick();
      in_valid = 1'b0;
      repeat (32) tick();
      check("done_flush pre_valid", {31'd0, out_valid_f}, 32'd1);
      flush = 1'b1;
      #1;
      check("done_flush valid", {31'd0, out_valid_f}, 32'd0);
      tick();
      flush = 1'b0;
      check("done_flush busy", {31'd0, busy_f}, 32'd0);

      // Asynchronous reset in the middle of CALC
      in_valid = 1'b1;
      op = 2'b00;
      src1 = 32'd1000;
      src2 = 32'd7;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst busy", {31'd0, busy_f}, 32'd0);
      check("mid_rst out_valid", {31'd0, out_valid_f}, 32'd0);
      check("mid_rst result", result_f, 32'd0);
      #3;
      reset = 1'b0;
      tick();
      check("mid_rst in_ready", {31'd0, in_ready_f}, 32'd1);
      no_valid_window("mid_rst");

      run_op("div_w after rst", 2'b00, 32'd1000, 32'd7, 32'd142, 32, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
